// File: rtl/pe_pkg.sv
// Shared PE types: coefficient width, coefficient type and
// the iterative multiplier state encoding.
package pe_pkg;

   localparam int COEF_W = 23;

   typedef logic [COEF_W-1:0] coef_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_t;

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first interleaved step: acc_next = (2*acc + bit*a) mod q.
// Both reductions are single conditional subtractions on W+1 bits.
module mod_mul_step #(
   parameter int W = 23
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] a,
   input  logic [W-1:0] q,
   input  logic         b_bit,
   output logic [W-1:0] acc_next
);

   logic [W:0] q_x;
   logic [W:0] dbl;
   logic [W:0] t;
   logic [W:0] sum;
   logic [W:0] u;

   assign q_x = {1'b0, q};
   assign dbl = {acc, 1'b0};
   assign t   = (dbl >= q_x) ? dbl - q_x : dbl;
   assign sum = b_bit ? t + {1'b0, a} : t;
   assign u   = (sum >= q_x) ? sum - q_x : sum;

   assign acc_next = u[W-1:0];

endmodule

// File: rtl/mod_mul_iter.sv
// Iterative modular multiplier c = (a*b) mod q, one multiplier
// bit per clock, with valid/ready handshakes on both sides.
module mod_mul_iter
   import pe_pkg::*;
#(
   parameter int W = COEF_W
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] q_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] c_o
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

   mul_state_t    state;
   logic [W-1:0]  acc;
   logic [W-1:0]  acc_next;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic [W-1:0]  q_r;

   mod_mul_step #(
      .W (W)
   ) u_step (
      .acc      (acc),
      .a        (a_r),
      .q        (q_r),
      .b_bit    (b_r[cnt]),
      .acc_next (acc_next)
   );

   // Handshake outputs and result are registered alongside the state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         q_r     <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
         c_o     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (valid_i) begin
                  a_r     <= a_i;
                  b_r     <= b_i;
                  q_r     <= q_i;
                  acc     <= '0;
                  cnt     <= CNT_MAX;
                  ready_o <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_next;
               if (cnt == '0) begin
                  c_o     <= acc_next;
                  valid_o <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  ready_o <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               valid_o <= 1'b0;
               ready_o <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
